// File: rtl/mux_matrix_scanner.sv
// Row/column address generator for a Rows x Cols mux matrix.
// Manual mode steps addresses from debounced buttons; auto mode rasters the array with an ADC handshake.
module mux_matrix_scanner #(
  parameter int unsigned Rows      = 4,
  parameter int unsigned Cols      = 4,
  parameter int unsigned RowWidth  = 5,
  parameter int unsigned ColWidth  = 5,
  parameter int unsigned HoldWidth = 29,
  parameter int unsigned SetWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 mode_i,
  input  logic                 brow_i,
  input  logic                 bcol_i,
  input  logic [HoldWidth-1:0] hold_k_i,
  input  logic [SetWidth-1:0]  settle_k_i,
  input  logic                 ack_i,
  output logic [RowWidth-1:0]  row_o,
  output logic [ColWidth-1:0]  col_o,
  output logic                 sample_o,
  output logic                 frame_o,
  output logic                 busy_o
);

  localparam logic [RowWidth-1:0] RowLast = RowWidth'(Rows - 1);
  localparam logic [ColWidth-1:0] ColLast = ColWidth'(Cols - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    REQ,
    NEXT
  } state_t;

  state_t               state;
  logic [SetWidth-1:0]  settle_cnt;
  logic [1:0]           btn;
  logic [1:0]           sync1;
  logic [1:0]           sync2;
  logic [1:0]           prev;
  logic [1:0]           tick;
  logic [HoldWidth-1:0] lock_cnt [2];
  logic [RowWidth-1:0]  row_inc;
  logic [ColWidth-1:0]  col_inc;

  assign btn = {bcol_i, brow_i};

  // Wrapping increments; >= keeps the address in range even from an out-of-range value.
  assign row_inc = (row_o >= RowLast) ? '0 : row_o + RowWidth'(1);
  assign col_inc = (col_o >= ColLast) ? '0 : col_o + ColWidth'(1);

  // Button synchroniser, edge detect and per-button lockout; bit 0 = row, bit 1 = column.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1       <= '0;
      sync2       <= '0;
      prev        <= '0;
      tick        <= '0;
      lock_cnt[0] <= '0;
      lock_cnt[1] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
      for (int i = 0; i < 2; i++) begin
        tick[i] <= 1'b0;
        if (lock_cnt[i] != '0) begin
          lock_cnt[i] <= lock_cnt[i] - HoldWidth'(1);
        end else if (sync2[i] && !prev[i]) begin
          tick[i]     <= 1'b1;
          lock_cnt[i] <= hold_k_i;
        end
      end
    end
  end

  // Scan FSM with registered address, request, frame and busy outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      row_o      <= '0;
      col_o      <= '0;
      settle_cnt <= '0;
      sample_o   <= 1'b0;
      frame_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      frame_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mode_i) begin
            state      <= SETTLE;
            row_o      <= '0;
            col_o      <= '0;
            settle_cnt <= '0;
            busy_o     <= 1'b1;
          end else begin
            if (tick[0]) row_o <= row_inc;
            if (tick[1]) col_o <= col_inc;
          end
        end
        SETTLE: begin
          if (!mode_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (settle_cnt == settle_k_i) begin
            state    <= REQ;
            sample_o <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + SetWidth'(1);
          end
        end
        REQ: begin
          // A started handshake always completes regardless of mode.
          if (ack_i) begin
            sample_o <= 1'b0;
            state    <= NEXT;
          end
        end
        NEXT: begin
          col_o      <= col_inc;
          settle_cnt <= '0;
          if (col_o >= ColLast) begin
            row_o <= row_inc;
            if (row_o >= RowLast) frame_o <= 1'b1;
          end
          if (mode_i) begin
            state <= SETTLE;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          sample_o <= 1'b0;
          busy_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_matrix_scanner.sv
// Randomised bench for mux_matrix_scanner: manual stepping with lockout, raster scan,
// mode drops and reset, all against a pixel-index / press-time reference model.
module tb_mux_matrix_scanner;

  localparam int Rows = 4;
  localparam int Cols = 3;
  localparam int Npix = Rows * Cols;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mode_i = 1'b0;
  logic        brow_i = 1'b0;
  logic        bcol_i = 1'b0;
  logic [28:0] hold_k_i = '0;
  logic [15:0] settle_k_i = '0;
  logic        ack_i = 1'b0;
  logic [4:0]  row_o;
  logic [4:0]  col_o;
  logic        sample_o;
  logic        frame_o;
  logic        busy_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int hold_m = 0;
  int row_m = 0;
  int col_m = 0;
  int last_r = -100000;
  int last_c = -100000;
  int pix = 0;

  mux_matrix_scanner #(
    .Rows(Rows),
    .Cols(Cols),
    .RowWidth(5),
    .ColWidth(5),
    .HoldWidth(29),
    .SetWidth(16)
  ) u_dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .mode_i(mode_i),
    .brow_i(brow_i),
    .bcol_i(bcol_i),
    .hold_k_i(hold_k_i),
    .settle_k_i(settle_k_i),
    .ack_i(ack_i),
    .row_o(row_o),
    .col_o(col_o),
    .sample_o(sample_o),
    .frame_o(frame_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one edge; outputs are observed and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic set_hold(input int h);
    hold_m   = h;
    hold_k_i = 29'(h);
  endtask

  // One button press held for two edges; address expected to move exactly 3 edges later.
  task automatic press(input bit r, input bit c);
    int  n;
    bit  acc_r;
    bit  acc_c;
    brow_i = r;
    bcol_i = c;
    tick();
    n = cyc;
    tick();
    brow_i = 1'b0;
    bcol_i = 1'b0;
    acc_r = r && ((n - last_r) > hold_m);
    acc_c = c && ((n - last_c) > hold_m);
    tick();
    chk("pre_row", 32'(row_o), 32'(row_m));
    chk("pre_col", 32'(col_o), 32'(col_m));
    if (acc_r) begin
      row_m  = (row_m + 1) % Rows;
      last_r = n;
    end
    if (acc_c) begin
      col_m  = (col_m + 1) % Cols;
      last_c = n;
    end
    tick();
    chk("step_row", 32'(row_o), 32'(row_m));
    chk("step_col", 32'(col_o), 32'(col_m));
  endtask

  // One auto pixel, starting just after the edge that entered SETTLE.
  task automatic pixel(input int settle, input int lat, input bit noisy, input bit drop_req);
    int cnt;
    int er;
    int ec;
    bit last;
    er  = (pix / Cols) % Rows;
    ec  = pix % Cols;
    cnt = 0;
    while (sample_o !== 1'b1 && cnt < 200) begin
      if (noisy) begin
        brow_i = 1'($urandom_range(0, 1));
        bcol_i = 1'($urandom_range(0, 1));
      end
      tick();
      cnt++;
    end
    chk("settle_len", 32'(cnt), 32'(settle + 1));
    chk("pix_row", 32'(row_o), 32'(er));
    chk("pix_col", 32'(col_o), 32'(ec));
    chk("busy_scan", 32'(busy_o), 32'd1);
    if (drop_req) mode_i = 1'b0;
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("req_hold", 32'(sample_o), 32'd1);
      chk("req_addr", 32'({row_o, col_o}), 32'({5'(er), 5'(ec)}));
    end
    ack_i = 1'b1;
    tick();
    ack_i  = 1'b0;
    brow_i = 1'b0;
    bcol_i = 1'b0;
    chk("ack_clr", 32'(sample_o), 32'd0);
    chk("ack_addr", 32'({row_o, col_o}), 32'({5'(er), 5'(ec)}));
    last = ((pix % Npix) == Npix - 1);
    pix++;
    tick();
    chk("frame", 32'(frame_o), 32'(last));
    chk("adv_row", 32'(row_o), 32'((pix / Cols) % Rows));
    chk("adv_col", 32'(col_o), 32'(pix % Cols));
    chk("busy_next", 32'(busy_o), 32'(mode_i));
  endtask

  task automatic start_auto();
    mode_i = 1'b1;
    tick();
    pix = 0;
    chk("auto_clr", 32'({row_o, col_o}), 32'd0);
  endtask

  initial begin
    int  tot;
    int  cnt;
    bit  seen;

    // Reset state
    idle(3);
    chk("rst_row", 32'(row_o), 32'd0);
    chk("rst_col", 32'(col_o), 32'd0);
    chk("rst_outs", 32'({sample_o, frame_o, busy_o}), 32'd0);
    rst_i = 1'b0;
    idle(2);

    // Manual wrap: five row presses 20 cycles apart
    set_hold(10);
    for (int i = 0; i < 5; i++) begin
      press(1'b1, 1'b0);
      idle(16);
    end
    chk("wrap_row", 32'(row_o), 32'd1);

    // Lockout: rises at t=0 and t=6 give one step, t=30 another, then both buttons together
    press(1'b1, 1'b0);
    idle(2);
    press(1'b1, 1'b0);
    idle(20);
    press(1'b1, 1'b0);
    idle(15);
    press(1'b1, 1'b1);
    idle(15);

    // Random manual presses with and without lockout
    for (int i = 0; i < 30; i++) begin
      bit r;
      bit c;
      r = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      if (!r && !c) r = 1'b1;
      press(r, c);
      idle($urandom_range(0, 14));
    end
    idle(12);
    set_hold(0);
    for (int i = 0; i < 12; i++) begin
      press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 3));
    end
    set_hold(10);
    idle(5);

    // Deterministic frame: settle 4, ack on the third REQ cycle
    settle_k_i = 16'd4;
    start_auto();
    for (int p = 0; p < Npix; p++) pixel(4, 3, 1'b0, (p == Npix - 1));
    chk("frame_done_busy", 32'(busy_o), 32'd0);
    row_m = 0;
    col_m = 0;

    // Random raster with button noise; drop mode during the final REQ
    idle(20);
    settle_k_i = 16'($urandom_range(0, 6));
    tot = 2 * Npix;
    start_auto();
    for (int p = 0; p < tot; p++)
      pixel(int'(settle_k_i), $urandom_range(1, 4), (p < tot - 2), (p == tot - 1));
    tick();
    chk("idle_after_drop", 32'({busy_o, row_o, col_o}), 32'd0);

    // Buttons step normally again once back in IDLE
    idle(20);
    last_r = -100000;
    last_c = -100000;
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'($urandom_range(0, 1)));
      idle(12);
    end

    // Mode drop during SETTLE: back to IDLE, address held, no request
    settle_k_i = 16'd2;
    start_auto();
    pixel(2, 1, 1'b0, 1'b0);
    tick();
    mode_i = 1'b0;
    tick();
    chk("drop_busy", 32'(busy_o), 32'd0);
    chk("drop_addr", 32'({row_o, col_o}), 32'({5'd0, 5'd1}));
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sample_o !== 1'b0) seen = 1'b1;
    end
    chk("drop_nosample", 32'(seen), 32'd0);
    row_m = 0;
    col_m = 1;

    // Reset in the middle of REQ
    settle_k_i = 16'd3;
    start_auto();
    cnt = 0;
    while (sample_o !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk("rst_req_seen", 32'(sample_o), 32'd1);
    tick();
    rst_i  = 1'b1;
    mode_i = 1'b0;
    tick();
    chk("midreq_rst", 32'({sample_o, frame_o, busy_o, row_o, col_o}), 32'd0);
    tick();
    rst_i = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sample_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    row_m  = 0;
    col_m  = 0;
    last_r = -100000;
    last_c = -100000;
    press(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
